// File: rtl/joy_pkg.sv
// joy_pkg: FSM encoding and sizing helpers shared by the
// serial joystick reader and its debounce bank.
package joy_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_LEAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } joy_state_t;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int frame_len(
    input int lead,
    input int players,
    input int bits
  );
    return lead + players * bits;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// joy_debounce: per-bit multi-frame filter; q[i] follows raw[i] only when
// raw and the last DEPTH-1 frames agree. Ports: clk, reset, raw, commit -> q, changed.
module joy_debounce
  import joy_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  input  logic             commit,
  output logic [WIDTH-1:0] q,
  output logic             changed
);

  logic [WIDTH-1:0] hi_ok;
  logic [WIDTH-1:0] lo_ok;
  logic [WIDTH-1:0] q_nxt;

  if (DEPTH > 1) begin : g_hist
    logic [WIDTH-1:0] hist [DEPTH-1];

    // hist[0] is the previous frame, older frames further up.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int d = 0; d < DEPTH-1; d++) hist[d] <= '1;
      end else if (commit) begin
        hist[0] <= raw;
        for (int d = 1; d < DEPTH-1; d++) hist[d] <= hist[d-1];
      end
    end

    always_comb begin
      hi_ok = '1;
      lo_ok = '1;
      for (int d = 0; d < DEPTH-1; d++) begin
        hi_ok = hi_ok & hist[d];
        lo_ok = lo_ok & ~hist[d];
      end
    end
  end else begin : g_nohist
    assign hi_ok = '1;
    assign lo_ok = '1;
  end

  // Set where every frame says released, clear where every frame says pressed.
  assign q_nxt = (q | (raw & hi_ok)) & ~(~raw & lo_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= '1;
      changed <= 1'b0;
    end else if (commit) begin
      q       <= q_nxt;
      changed <= (q_nxt != q);
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: rtl/joy_serial_reader.sv
// joy_serial_reader: drives joy_clk/joy_load, shifts in joy_data, debounces into joy_o.
// Ports: clk, reset, joy_data -> joy_clk, joy_load, joy_o, frame_done, joy_changed.
module joy_serial_reader
  import joy_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int BITS_PER_PLAYER = 12,
  parameter int CLK_DIV         = 32,
  parameter int LEAD_CYCLES     = 2,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic joy_data,
  output logic joy_clk,
  output logic joy_load,
  output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joy_o,
  output logic frame_done,
  output logic joy_changed
);

  localparam int DATA_BITS = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int FRAME_LEN =
    frame_len(LEAD_CYCLES, NUM_PLAYERS, BITS_PER_PLAYER);
  localparam int HALF = CLK_DIV / 2;
  localparam int DW = clog2(CLK_DIV);
  localparam int BW = clog2(FRAME_LEN);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [BW-1:0] bit_cnt;
  logic          tick;
  joy_state_t    state;
  joy_state_t    state_nxt;
  logic          shift_en;
  logic          commit;
  logic [DATA_BITS-1:0] raw;

  assign div_nxt = (div_cnt == DW'(CLK_DIV-1)) ? '0 : div_cnt + 1'b1;
  assign tick = (div_cnt == DW'(HALF-1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  // bit_cnt names the joy_clk period that the next tick opens.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD:
        if (tick)
          state_nxt = (LEAD_CYCLES > 1) ? ST_LEAD : ST_SHIFT;
      ST_LEAD:
        if (tick && bit_cnt == BW'(LEAD_CYCLES-1))
          state_nxt = ST_SHIFT;
      ST_SHIFT:
        if (tick && bit_cnt == BW'(FRAME_LEN-1))
          state_nxt = ST_COMMIT;
      ST_COMMIT:
        state_nxt = ST_LOAD;
      default:
        state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    commit   = 1'b0;
    unique case (1'b1)
      (state == ST_SHIFT):  shift_en = tick;
      (state == ST_COMMIT): commit   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      joy_clk    <= 1'b0;
      joy_load   <= 1'b1;
      raw        <= '1;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      joy_clk    <= (div_nxt >= DW'(HALF));
      frame_done <= commit;
      if (tick) begin
        joy_load <= (bit_cnt != '0);
        bit_cnt  <= (bit_cnt == BW'(FRAME_LEN-1)) ? '0 : bit_cnt + 1'b1;
      end
      // Shift right so the first data bit ends up in raw[0].
      if (shift_en)
        raw <= DATA_BITS'({joy_data, raw} >> 1);
    end
  end

  joy_debounce #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk(clk),
    .reset(reset),
    .raw(raw),
    .commit(commit),
    .q(joy_o),
    .changed(joy_changed)
  );

endmodule

// File: tb/tb_joy_serial_reader.sv
// tb_joy_serial_reader: random and directed checks of three reader configs
// against a shift-register source and a frame-level debounce model.
module tb_joy_serial_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic d_data = 1'b1, d_clk, d_load, d_done, d_chg;
  logic [23:0] d_o;
  logic n_data = 1'b1, n_clk, n_load, n_done, n_chg;
  logic [23:0] n_o;
  logic g_data = 1'b1, g_clk, g_load, g_done, g_chg;
  logic [31:0] g_o;

  joy_serial_reader u_def (
    .clk(clk), .reset(reset), .joy_data(d_data),
    .joy_clk(d_clk), .joy_load(d_load), .joy_o(d_o),
    .frame_done(d_done), .joy_changed(d_chg)
  );

  joy_serial_reader #(.DEBOUNCE_FRAMES(1)) u_nf (
    .clk(clk), .reset(reset), .joy_data(n_data),
    .joy_clk(n_clk), .joy_load(n_load), .joy_o(n_o),
    .frame_done(n_done), .joy_changed(n_chg)
  );

  joy_serial_reader #(
    .NUM_PLAYERS(4), .BITS_PER_PLAYER(8),
    .CLK_DIV(4), .LEAD_CYCLES(1)
  ) u_gen (
    .clk(clk), .reset(reset), .joy_data(g_data),
    .joy_clk(g_clk), .joy_load(g_load), .joy_o(g_o),
    .frame_done(g_done), .joy_changed(g_chg)
  );

  // External shift register: loaded while joy_load is low, then one
  // bit per joy_clk rise, with LEAD-1 filler stages ahead of bit 0.
  logic [31:0] d_word = '1, n_word = '1, g_word = '1;
  bit src_zero = 1'b0;
  int d_n = 1000, n_n = 1000, g_n = 1000;
  logic d_pc = 1'b0, n_pc = 1'b0, g_pc = 1'b0;

  function automatic logic src_bit(logic [31:0] w, int idx, int nb);
    if (idx < 0 || idx >= nb) return 1'b1;
    return w[idx];
  endfunction

  always @(negedge clk) begin
    if (!d_load) d_n = 0; else if (d_clk && !d_pc) d_n++;
    if (!n_load) n_n = 0; else if (n_clk && !n_pc) n_n++;
    if (!g_load) g_n = 0; else if (g_clk && !g_pc) g_n++;
    d_pc = d_clk;
    n_pc = n_clk;
    g_pc = g_clk;
    d_data = src_zero ? 1'b0 : src_bit(d_word, d_n - 1, 24);
    n_data = src_zero ? 1'b0 : src_bit(n_word, n_n - 1, 24);
    g_data = src_zero ? 1'b0 : src_bit(g_word, g_n, 32);
  end

  // Frame-level filter: a bit takes a value once the newest
  // `depth` frames all carry it; h0 is the newest frame.
  function automatic logic [31:0] deb(
    input logic [31:0] h0, h1, h2, h3,
    input int depth, input logic [31:0] prev
  );
    logic [31:0] r;
    logic [3:0] v, m;
    r = prev;
    m = 4'((1 << depth) - 1);
    for (int i = 0; i < 32; i++) begin
      v = {h3[i], h2[i], h1[i], h0[i]};
      if ((v & m) == m) r[i] = 1'b1;
      else if ((v & m) == 4'd0) r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int sel, output bit ok);
    int lim;
    lim = (sel == 2) ? 400 : 2000;
    ok = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if ((sel == 0 && d_done) || (sel == 1 && n_done) ||
          (sel == 2 && g_done)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen_done;
    int c;
    @(negedge clk);
    reset = 1'b1;
    src_zero = 1'b1;
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (d_done) seen_done = 1'b1;
    end
    total++;
    if (d_o !== 24'hFFFFFF) begin
      bad++;
      $display("FAIL reset_joy_o got=%h want=ffffff", d_o);
    end
    total++;
    if (d_load !== 1'b1 || d_clk !== 1'b0) begin
      bad++;
      $display("FAIL reset_pins got load=%b clk=%b want 1 0", d_load, d_clk);
    end
    total++;
    if (seen_done) begin
      bad++;
      $display("FAIL reset_done got=1 want=0");
    end
    src_zero = 1'b0;
    reset = 1'b0;
    c = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!d_load) begin
        c = k;
        break;
      end
    end
    total++;
    if (c != 16) begin
      bad++;
      $display("FAIL reset_first_load got=%0d want=16", c);
    end
  endtask

  task automatic test_timing();
    int lf[$], lr[$], cr[$], cf[$], dn[$];
    logic pl, pc, pd;
    bit dbl;
    int low, high;
    do_reset();
    pl = d_load; pc = d_clk; pd = d_done; dbl = 1'b0;
    for (int t = 1; t <= 1800; t++) begin
      @(negedge clk);
      if (pl && !d_load) lf.push_back(t);
      if (!pl && d_load) lr.push_back(t);
      if (!pc && d_clk) cr.push_back(t);
      if (pc && !d_clk) cf.push_back(t);
      if (d_done) dn.push_back(t);
      if (pd && d_done) dbl = 1'b1;
      pl = d_load; pc = d_clk; pd = d_done;
    end
    total++;
    if (lf.size() < 2 || lf[1] - lf[0] != 832) begin
      bad++;
      $display("FAIL load_period got=%0d want=832",
               lf.size() < 2 ? -1 : lf[1] - lf[0]);
    end
    low = -1;
    if (lf.size() > 0)
      foreach (lr[i]) if (low < 0 && lr[i] > lf[0]) low = lr[i] - lf[0];
    total++;
    if (low != 32) begin
      bad++;
      $display("FAIL load_low got=%0d want=32", low);
    end
    total++;
    if (cr.size() < 2 || cr[1] - cr[0] != 32) begin
      bad++;
      $display("FAIL clk_period got=%0d want=32",
               cr.size() < 2 ? -1 : cr[1] - cr[0]);
    end
    high = -1;
    if (cr.size() > 0)
      foreach (cf[i]) if (high < 0 && cf[i] > cr[0]) high = cf[i] - cr[0];
    total++;
    if (high != 16) begin
      bad++;
      $display("FAIL clk_high got=%0d want=16", high);
    end
    total++;
    if (dn.size() < 2 || dn[1] - dn[0] != 832 || dbl) begin
      bad++;
      $display("FAIL done_period got=%0d dbl=%0d want=832 0",
               dn.size() < 2 ? -1 : dn[1] - dn[0], dbl);
    end
  endtask

  task automatic test_capture();
    logic [31:0] w, prev, exp;
    logic ec;
    bit ok;
    n_word = 32'h00123ABC;
    do_reset();
    prev = '1;
    for (int f = 0; f < 6; f++) begin
      w = n_word;
      exp = deb(w, '1, '1, '1, 1, prev);
      ec = (exp[23:0] != prev[23:0]);
      wait_done(1, ok);
      total++;
      if (!ok || n_o !== exp[23:0] || n_chg !== ec) begin
        bad++;
        $display("FAIL capture_f%0d got=%h chg=%b want=%h chg=%b",
                 f, n_o, n_chg, exp[23:0], ec);
      end
      prev = exp;
      if (f >= 1) n_word = {8'h0, 24'($urandom())};
    end
  endtask

  task automatic test_debounce();
    logic [23:0] w [5] = '{24'hFFFFF7, 24'hFFFFFF, 24'hFFFFF7,
                           24'hFFFFF7, 24'hFFFFF7};
    logic [23:0] eo [5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                            24'hFFFFF7, 24'hFFFFF7};
    logic ec [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] h0, h1, prev, exp;
    logic ech;
    bit ok;
    d_word = {8'hFF, w[0]};
    do_reset();
    for (int f = 0; f < 5; f++) begin
      wait_done(0, ok);
      total++;
      if (!ok || d_o !== eo[f] || d_chg !== ec[f]) begin
        bad++;
        $display("FAIL debounce_f%0d got=%h chg=%b want=%h chg=%b",
                 f, d_o, d_chg, eo[f], ec[f]);
      end
      if (f < 4) d_word = {8'hFF, w[f+1]};
    end
    h0 = {8'hFF, w[4]};
    prev = {8'hFF, eo[4]};
    for (int f = 0; f < 6; f++) begin
      d_word = {8'hFF, h0[23:0] ^ 24'($urandom() & $urandom() & $urandom())};
      if (f == 3) d_word = h0;
      h1 = h0;
      h0 = d_word;
      exp = deb(h0, h1, '1, '1, 2, prev);
      ech = (exp[23:0] != prev[23:0]);
      wait_done(0, ok);
      total++;
      if (!ok || d_o !== exp[23:0] || d_chg !== ech) begin
        bad++;
        $display("FAIL debounce_rand%0d got=%h chg=%b want=%h chg=%b",
                 f, d_o, d_chg, exp[23:0], ech);
      end
      prev = exp;
    end
  endtask

  task automatic test_midreset();
    logic pc;
    int rises, lfall, first;
    bit ok, early;
    d_word = '0;
    wait_done(0, ok);
    wait_done(0, ok);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!d_load) break;
    end
    rises = 0;
    pc = d_clk;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (d_clk && !pc) rises++;
      pc = d_clk;
      if (rises == 10) break;
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (d_o !== 24'hFFFFFF || d_load !== 1'b1 || d_clk !== 1'b0 ||
        d_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset got o=%h load=%b clk=%b done=%b want ffffff 1 0 0",
               d_o, d_load, d_clk, d_done);
    end
    reset = 1'b0;
    lfall = -1; first = -1; early = 1'b0;
    for (int t = 1; t <= 1000; t++) begin
      @(negedge clk);
      if (lfall < 0 && !d_load) lfall = t;
      if (d_done && lfall < 0) early = 1'b1;
      if (d_done && first < 0) begin
        first = t;
        break;
      end
    end
    total++;
    if (lfall != 16 || early || first < 0) begin
      bad++;
      $display("FAIL midreset_restart got load=%0d early=%0d done=%0d want 16 0 >0",
               lfall, early, first);
    end
    total++;
    if (d_o !== 24'hFFFFFF || d_chg !== 1'b0) begin
      bad++;
      $display("FAIL midreset_f0 got=%h chg=%b want=ffffff 0", d_o, d_chg);
    end
    wait_done(0, ok);
    total++;
    if (!ok || d_o !== 24'h000000 || d_chg !== 1'b1) begin
      bad++;
      $display("FAIL midreset_f1 got=%h chg=%b want=000000 1", d_o, d_chg);
    end
  endtask

  task automatic test_general();
    logic [31:0] h0, h1, prev, exp;
    logic ech;
    int tprev, per;
    bit ok;
    g_word = 32'h81FF005A;
    do_reset();
    h0 = '1;
    prev = '1;
    tprev = -1;
    for (int f = 0; f < 8; f++) begin
      h1 = h0;
      h0 = g_word;
      exp = deb(h0, h1, '1, '1, 2, prev);
      ech = (exp != prev);
      per = 0;
      ok = 1'b0;
      for (int c = 1; c <= 400; c++) begin
        @(negedge clk);
        if (g_done) begin
          ok = 1'b1;
          per = c;
          break;
        end
      end
      total++;
      if (!ok || g_o !== exp || g_chg !== ech) begin
        bad++;
        $display("FAIL general_f%0d got=%h chg=%b want=%h chg=%b",
                 f, g_o, g_chg, exp, ech);
      end
      if (f == 1) begin
        total++;
        if (per != 132) begin
          bad++;
          $display("FAIL general_period got=%0d want=132", per);
        end
      end
      prev = exp;
      if (f >= 1) g_word = (f % 2 == 1) ? $urandom() : g_word;
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_capture();
    test_debounce();
    test_midreset();
    test_general();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
